// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch: sequential req/gnt/rvalid fetch into a FIFO with branch redirect.
// Define INSTR_PREFETCH_BYPASS_EN to forward responses straight to the core when the FIFO is empty.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_ready_i,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [31:0] BOOT = {BOOT_ADDR[31:2], 2'b00};

  logic [31:0]   fetch_addr_q;
  logic [31:0]   held_addr_q;
  logic          req_held_q;
  logic          held_stale_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] discard_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [PW-1:0] f_wr_q;
  logic [PW-1:0] f_rd_q;
  logic [PW-1:0] t_wr_q;
  logic [PW-1:0] t_rd_q;
  logic [31:0]   fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   tag_q       [DEPTH];

  logic [CW:0]   fill_sum;
  logic          new_req;
  logic          req;
  logic [31:0]   req_addr;
  logic          gnt;
  logic          stale_gnt;
  logic          keep;
  logic          fifo_empty;
  logic          bypass;
  logic          valid;
  logic          pop_fifo;
  logic          push;
  logic [CW-1:0] outst_d;
  logic [CW-1:0] discard_d;
  logic          unused_bits;

  assign unused_bits = ^branch_addr_i[1:0];

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // An ungranted request owns the bus until granted.
  assign fill_sum = {1'b0, fifo_cnt_q}
                  + {1'b0, outst_q};
  assign new_req  = fetch_enable_i && !branch_i
                 && (fill_sum < (CW+1)'(DEPTH));
  assign req      = req_held_q || new_req;
  assign req_addr = req_held_q ? held_addr_q
                               : fetch_addr_q;
  assign gnt       = req && mem_gnt_i;
  assign stale_gnt = gnt && req_held_q
                  && held_stale_q;

  assign mem_req_o  = req;
  assign mem_addr_o = req ? req_addr : '0;

  assign keep = mem_rvalid_i && !branch_i
             && (discard_q == '0);
  assign fifo_empty = (fifo_cnt_q == '0);

`ifdef INSTR_PREFETCH_BYPASS_EN
  assign bypass = keep && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign valid = !branch_i
              && (!fifo_empty || bypass);
  assign pop_fifo = valid && instr_ready_i
                 && !fifo_empty;
  assign push = keep
             && !(bypass && instr_ready_i);

  assign instr_valid_o = valid;
  assign instr_rdata_o = !valid ? '0
                       : fifo_empty ? mem_rdata_i
                       : fifo_data_q[f_rd_q];
  assign instr_addr_o  = !valid ? '0
                       : fifo_empty ? tag_q[t_rd_q]
                       : fifo_addr_q[f_rd_q];

  assign busy_o = (outst_q != '0)
               || (discard_q != '0);

  assign outst_d = outst_q + CW'(gnt)
                 - CW'(mem_rvalid_i);

  // A stale held request joins the discard count when it finally lands.
  always_comb begin
    discard_d = discard_q;
    if (branch_i) begin
      discard_d = outst_d;
    end else begin
      if (mem_rvalid_i && (discard_q != '0))
        discard_d = discard_d - CW'(1);
      if (stale_gnt)
        discard_d = discard_d + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_addr_q <= BOOT;
      held_addr_q  <= '0;
      req_held_q   <= 1'b0;
      held_stale_q <= 1'b0;
      outst_q      <= '0;
      discard_q    <= '0;
      fifo_cnt_q   <= '0;
      f_wr_q       <= '0;
      f_rd_q       <= '0;
      t_wr_q       <= '0;
      t_rd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
        tag_q[i]       <= '0;
      end
    end else begin
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      req_held_q <= req && !mem_gnt_i;
      if (req && !req_held_q)
        held_addr_q <= fetch_addr_q;

      if (gnt)
        held_stale_q <= 1'b0;
      else if (branch_i && req_held_q)
        held_stale_q <= 1'b1;

      if (branch_i)
        fetch_addr_q <= {branch_addr_i[31:2], 2'b00};
      else if (gnt && !stale_gnt)
        fetch_addr_q <= fetch_addr_q + 32'd4;

      if (gnt) begin
        tag_q[t_wr_q] <= req_addr;
        t_wr_q        <= inc(t_wr_q);
      end
      if (mem_rvalid_i)
        t_rd_q <= inc(t_rd_q);

      if (branch_i) begin
        fifo_cnt_q <= '0;
        f_wr_q     <= '0;
        f_rd_q     <= '0;
      end else begin
        fifo_cnt_q <= fifo_cnt_q + CW'(push)
                    - CW'(pop_fifo);
        if (push) begin
          fifo_addr_q[f_wr_q] <= tag_q[t_rd_q];
          fifo_data_q[f_wr_q] <= mem_rdata_i;
          f_wr_q              <= inc(f_wr_q);
        end
        if (pop_fifo)
          f_rd_q <= inc(f_rd_q);
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: memory model with random grant/latency,
// PC-stream scoreboard, branch-target table and directed corner sequences.
module tb_instr_prefetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0080;
  localparam logic [31:0] NONE  = 32'hDEAD_DEAD;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_enable_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_ready_i;
  logic        busy_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;

  instr_prefetch_buffer #(
    .DEPTH     (DEPTH),
    .BOOT_ADDR (BOOT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fetch_enable_i (fetch_enable_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .instr_valid_o  (instr_valid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_addr_o   (instr_addr_o),
    .instr_ready_i  (instr_ready_i),
    .busy_o         (busy_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_rvalid_i   (mem_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] a0, a1, a2;
    logic [31:0] d0, d1, d2;
  } vec_t;

  resp_t       rq[$];
  logic [31:0] sb_q[$];
  logic [31:0] sb_next;
  logic [31:0] dlv_q[$];
  logic [31:0] dlv_d_q[$];
  int          dlv_c_q[$];
  logic [31:0] gnt_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cnt, rv_cnt, dlv_cnt;

  bit          en, en_rand, br_req, rv_rand;
  logic [31:0] br_tgt;
  int          gnt_mode, rdy_mode, lat_min, lat_max;
  bit          hold_prev;
  logic [31:0] hold_addr;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, req);
    end
  endtask

  task automatic chk_true(input string nm,
                          input bit cond);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s act=0 exp=1", nm);
    end
  endtask

  task automatic sb_fill();
    while (sb_q.size() < 8) begin
      sb_q.push_back(sb_next);
      sb_next = sb_next + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] t);
    sb_q.delete();
    sb_next = {t[31:2], 2'b00};
    sb_fill();
  endtask

  // One clock: drive at negedge, sample 1ns later.
  task automatic step();
    logic [31:0] e;
    @(negedge clk_i);
    cyc++;
    branch_i      = br_req;
    branch_addr_i = br_tgt;
    br_req        = 1'b0;
    fetch_enable_i = en_rand
      ? ($urandom_range(9, 0) != 0) : en;
    case (gnt_mode)
      0:       mem_gnt_i = 1'b1;
      1:       mem_gnt_i = ($urandom_range(9, 0) < 7);
      default: mem_gnt_i = 1'b0;
    endcase
    if (rq.size() > 0 && rq[0].due <= cyc &&
        (!rv_rand || $urandom_range(9, 0) < 7)) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rq[0].addr >> 2;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
    case (rdy_mode)
      0:       instr_ready_i = 1'b1;
      1:       instr_ready_i = ($urandom_range(3, 0) != 0);
      default: instr_ready_i = 1'b0;
    endcase
    #1;
    if (hold_prev)
      chk("bus_hold", {31'b0, mem_req_o, mem_addr_o},
          {32'h1, hold_addr});
    hold_prev = mem_req_o && !mem_gnt_i;
    hold_addr = mem_addr_o;
    if (mem_rvalid_i) begin
      void'(rq.pop_front());
      rv_cnt++;
    end
    if (mem_req_o && mem_gnt_i) begin
      gnt_cnt++;
      gnt_log.push_back(mem_addr_o);
      rq.push_back('{mem_addr_o, cyc + 1 +
        int'($urandom_range(lat_max, lat_min))});
      if (rq.size() > DEPTH)
        chk_true("outstanding_cap", 1'b0);
    end
    if (branch_i) begin
      chk("branch_valid", instr_valid_o, 0);
      sb_restart(branch_addr_i);
      dlv_q.delete();
      dlv_d_q.delete();
      dlv_c_q.delete();
    end else if (instr_valid_o && instr_ready_i) begin
      e = sb_q.pop_front();
      sb_fill();
      chk("stream", {instr_addr_o, instr_rdata_o},
          {e, e >> 2});
      dlv_q.push_back(instr_addr_o);
      dlv_d_q.push_back(instr_rdata_o);
      dlv_c_q.push_back(cyc);
      dlv_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_ni         = 1'b0;
    en             = 1'b0;
    en_rand        = 1'b0;
    fetch_enable_i = 1'b0;
    branch_i       = 1'b0;
    branch_addr_i  = '0;
    mem_gnt_i      = 1'b0;
    mem_rvalid_i   = 1'b0;
    mem_rdata_i    = '0;
    instr_ready_i  = 1'b0;
    #1;
    chk("rst_ctrl", {instr_valid_o, mem_req_o, busy_o}, 0);
    chk("rst_instr", {instr_addr_o, instr_rdata_o}, 0);
    chk("rst_maddr", mem_addr_o, 0);
    rq.delete();
    hold_prev = 1'b0;
    sb_restart(BOOT);
    dlv_q.delete();
    dlv_d_q.delete();
    dlv_c_q.delete();
    gnt_log.delete();
    gnt_cnt = 0;
    rv_cnt  = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    vec_t        tbl[4];
    logic [31:0] v;
    int          r0, d0;

    tbl[0] = '{32'h0000_1002, 32'h0000_1000, 32'h0000_1004,
               32'h0000_1008, 32'h0000_0400, 32'h0000_0401,
               32'h0000_0402};
    tbl[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
               32'h0000_0000, 32'h3FFF_FFFE, 32'h3FFF_FFFF,
               32'h0000_0000};
    tbl[2] = '{32'h0000_0083, 32'h0000_0080, 32'h0000_0084,
               32'h0000_0088, 32'h0000_0020, 32'h0000_0021,
               32'h0000_0022};
    tbl[3] = '{32'h1234_5679, 32'h1234_5678, 32'h1234_567C,
               32'h1234_5680, 32'h048D_159E, 32'h048D_159F,
               32'h048D_15A0};

    br_req = 1'b0; br_tgt = '0; rv_rand = 1'b0;
    gnt_mode = 0; rdy_mode = 0;
    lat_min = 0; lat_max = 0; dlv_cnt = 0;

    // Boot stream and throughput.
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 40 && dlv_q.size() < 8; i++) step();
    chk_true("boot_count", dlv_q.size() >= 8);
    if (dlv_q.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("boot_addr", dlv_q[i], BOOT + 32'(4 * i));
        chk("boot_data", dlv_d_q[i], 32'h20 + 32'(i));
      end
      chk("throughput", dlv_c_q[7] - dlv_c_q[0], 7);
    end

    // Core stalled: FIFO fills, requests stop.
    do_reset();
    en = 1'b1;
    rdy_mode = 2;
    repeat (20) step();
    chk("stall_gnts", gnt_cnt, 4);
    chk("stall_req", mem_req_o, 0);
    chk("stall_valid", instr_valid_o, 1);
    rdy_mode = 0;
    for (int i = 0; i < 60 && dlv_q.size() < 12; i++) step();
    chk_true("stall_resume", dlv_q.size() >= 12);

    // Branch with two responses in flight.
    do_reset();
    en = 1'b1;
    lat_min = 6; lat_max = 6;
    for (int i = 0; i < 20 && gnt_cnt < 2; i++) step();
    chk("br2_gnts", gnt_cnt, 2);
    en = 1'b0;
    br_req = 1'b1;
    br_tgt = 32'h0000_1002;
    r0 = rv_cnt;
    step();
    chk("br2_busy", busy_o, 1);
    gnt_mode = 2;
    en = 1'b1;
    for (int i = 0; i < 30 && busy_o; i++) step();
    chk("br2_drops", rv_cnt - r0, 2);
    chk("br2_idle", busy_o, 0);
    chk("br2_nodlv", dlv_q.size(), 0);
    chk("br2_req", {mem_req_o, mem_addr_o},
        {1'b1, 32'h0000_1000});
    gnt_mode = 0;
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 30 && dlv_q.size() == 0; i++) step();
    v = (dlv_q.size() > 0) ? dlv_q[0] : NONE;
    chk("br2_first", v, 32'h0000_1000);

    // Branch while a request is held ungranted.
    do_reset();
    en = 1'b1;
    gnt_mode = 2;
    repeat (4) step();
    br_req = 1'b1;
    br_tgt = 32'h0000_2000;
    step();
    repeat (2) step();
    chk("held_req", {mem_req_o, mem_addr_o},
        {1'b1, 32'h0000_0080});
    gnt_mode = 0;
    for (int i = 0; i < 30 && dlv_q.size() == 0; i++) step();
    v = (gnt_log.size() > 0) ? gnt_log[0] : NONE;
    chk("held_gnt0", v, 32'h0000_0080);
    v = (gnt_log.size() > 1) ? gnt_log[1] : NONE;
    chk("held_gnt1", v, 32'h0000_2000);
    v = (dlv_q.size() > 0) ? dlv_q[0] : NONE;
    chk("held_first", v, 32'h0000_2000);

    // Branch-target table.
    lat_min = 0; lat_max = 2;
    for (int k = 0; k < 4; k++) begin
      br_req = 1'b1;
      br_tgt = tbl[k].tgt;
      step();
      for (int i = 0; i < 40 && dlv_q.size() < 3; i++) step();
      chk_true("tbl_count", dlv_q.size() >= 3);
      if (dlv_q.size() >= 3) begin
        chk("tbl_a0", dlv_q[0], tbl[k].a0);
        chk("tbl_a1", dlv_q[1], tbl[k].a1);
        chk("tbl_a2", dlv_q[2], tbl[k].a2);
        chk("tbl_d0", dlv_d_q[0], tbl[k].d0);
        chk("tbl_d1", dlv_d_q[1], tbl[k].d1);
        chk("tbl_d2", dlv_d_q[2], tbl[k].d2);
      end
    end

    // Random grants, latencies, stalls and branches.
    do_reset();
    en_rand = 1'b1;
    gnt_mode = 1;
    rdy_mode = 1;
    rv_rand = 1'b1;
    lat_min = 0; lat_max = 3;
    d0 = dlv_cnt;
    for (int i = 0; i < 20000 && dlv_cnt - d0 < 1000; i++) begin
      if ($urandom_range(99, 0) < 3) begin
        br_req = 1'b1;
        br_tgt = $urandom;
      end
      step();
    end
    chk_true("rand_count", dlv_cnt - d0 >= 1000);

    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_buffer.md
# instr_prefetch_buffer

Instruction prefetch stage between the core fetch unit and the instruction port of the simulation memory. It issues sequential word fetches on a req/gnt/rvalid bus and tolerates random grant stalls and in-order responses. Fetched words are buffered in a FIFO and handed to the core with a valid/ready handshake. A branch redirects the stream, and responses still in flight from the old stream are discarded.

## Interface
- DEPTH, 4: FIFO entries; also the cap on entries plus in-flight requests (≥2).
- BOOT_ADDR, 32'h0000_0000: first fetch address after reset (bits [1:0] ignored).
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- fetch_enable_i  in  1  permits new requests
- branch_i  in  1  one-cycle redirect strobe
- branch_addr_i  in  32  redirect target, word-aligned internally
- instr_valid_o  out  1  output word valid
- instr_rdata_o  out  32  instruction word
- instr_addr_o  out  32  address of instr_rdata_o
- instr_ready_i  in  1  core accepts word
- busy_o  out  1  requests outstanding or being discarded
- mem_req_o  out  1  memory request
- mem_addr_o  out  32  word-aligned request address
- mem_gnt_i  in  1  request accepted this cycle
- mem_rdata_i  in  32  response data
- mem_rvalid_i  in  1  response valid, in order, ≥1 cycle after its grant

## Operation
- Registers:
  - fetch_addr, reset to {BOOT_ADDR[31:2],2'b00}.
  - FIFO of {addr,data}.
  - outstanding counter, width $clog2(DEPTH+1).
  - discard counter, same width.
- Issue rule: mem_req_o = 1 when fetch_enable_i=1, no branch this cycle, and fifo_count + outstanding < DEPTH. The FIFO can never overflow.
- Bus rule: once mem_req_o is asserted without a grant, mem_req_o and mem_addr_o hold stable until mem_gnt_i. This holds even if fetch_enable_i drops or branch_i arrives.
- On grant:
  - outstanding += 1.
  - The address of the granted request is pushed into an address-tag queue.
  - fetch_addr += 4, wrapping modulo 2^32 (32'hFFFF_FFFC → 0).
- On mem_rvalid_i:
  - outstanding −= 1.
  - If discard > 0: discard −= 1 and the response is dropped.
  - Otherwise {tag, mem_rdata_i} is pushed to the FIFO.
- Simultaneous grant and rvalid: the counter is unchanged.
- On branch_i:
  - FIFO flushed.
  - discard = outstanding after this cycle's updates, including a grant in the same cycle.
  - fetch_addr = {branch_addr_i[31:2],2'b00}.
  - An rvalid in the branch cycle is dropped; it does not decrement discard.
  - A pop in the branch cycle is ignored; instr_valid_o is forced 0 that cycle.
  - A request still held ungranted completes under the bus rule and is added to discard when granted.
- Output: instr_valid_o = FIFO non-empty. Pop when instr_valid_o && instr_ready_i.
- busy_o = (outstanding != 0) || (discard != 0).

## Timing
- Reset values: all outputs 0; counters 0; FIFO empty.
- Reset is asynchronous and clears everything mid-operation. In-flight responses after reset are the memory's concern, since memory reset clears its queue.
- Branch in cycle N → mem_req_o with the target address in cycle N+1, unless a request is held ungranted. In that case, the cycle after that request's grant.
- Grant in cycle M → response at ≥M+1 → instr_valid_o one cycle after mem_rvalid_i.
- Back-to-back grants sustain one word per cycle when the core is always ready.
- FIFO full: no request is issued; the held-request rule still applies.
- FIFO empty with ready=1: instr_valid_o = 0; no pop occurs.

## Configuration
- INSTR_PREFETCH_BYPASS_EN defined: when the FIFO is empty, mem_rvalid_i=1, the response is not discarded and no branch is active, the response drives instr_valid_o, instr_rdata_o and instr_addr_o combinationally in the same cycle. If instr_ready_i=1, it is consumed without a FIFO write; otherwise it is written to the FIFO.
- Not defined: every response goes through the FIFO, giving one cycle of added latency. All other behaviour is identical.

## Test plan
- Reset with BOOT_ADDR=32'h80, memory filled with words i at address 4i, constant grant, ready=1 → addresses 0x80, 0x84, 0x88… in order with data 0x20, 0x21…; throughput one word per cycle after fill.
- instr_ready_i=0 for 20 cycles, DEPTH=4 → exactly 4 grants total; FIFO full; mem_req_o stays 0; releasing ready resumes with no loss or duplication.
- Branch to 0x1002 while 2 requests are outstanding → both responses dropped; the first delivered word has addr 0x1000; busy_o returns to 0 after the second drop.
- Branch while a request is held ungranted for 3 cycles → mem_addr_o stays stable until the grant; that response is dropped; the next request uses the branch target.
- fetch_addr 0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Random grant and response delays with 1000 instructions and random branches → delivered stream matches a reference sequence of PCs and memory contents; no FIFO overflow; bypass and non-bypass builds are both checked.
